// File: rtl/matvec_mul.sv
// Pipelined signed matrix-vector multiplier y = K * x.
// One multiplier stage followed by a registered binary adder tree per row.
module matvec_mul #(
    parameter int R   = 2,
    parameter int C   = 5,
    parameter int W_X = 3,
    parameter int W_K = 4
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            cen,
    input  logic [R-1:0][C-1:0][W_K-1:0]                    k,
    input  logic [C-1:0][W_X-1:0]                           x,
    output logic [R-1:0][W_X+W_K+$clog2(C)-1:0]             y
);

    localparam int W_P     = W_X + W_K;
    localparam int LEVELS  = $clog2(C);
    localparam int W_Y     = W_P + LEVELS;
    localparam int LATENCY = LEVELS + 1;

    // Every level is stored at full output width; the tree sums can never
    // exceed W_Y, so the upper bits are plain sign extension.
    for (genvar gi = 0; gi < LATENCY; gi++) begin : lvl
        localparam int N = (C + (1 << gi) - 1) >> gi;
        logic signed [W_Y-1:0] node [R][N];

        if (gi == 0) begin : g_mul
            logic signed [W_Y-1:0] prod [R][C];
            for (genvar gr = 0; gr < R; gr++) begin : g_row
                for (genvar gc = 0; gc < C; gc++) begin : g_col
                    logic signed [W_P-1:0] ka;
                    logic signed [W_P-1:0] xa;
                    logic signed [W_P-1:0] pa;
                    assign ka = W_P'($signed(k[gr][gc]));
                    assign xa = W_P'($signed(x[gc]));
                    assign pa = ka * xa;
                    assign prod[gr][gc] = W_Y'(pa);
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    node <= '{default: '0};
                end else if (cen) begin
                    node <= prod;
                end
            end
        end else begin : g_add
            localparam int PN = (C + (1 << (gi - 1)) - 1) >> (gi - 1);
            logic signed [W_Y-1:0] sum [R][N];
            for (genvar gr = 0; gr < R; gr++) begin : g_row
                for (genvar gn = 0; gn < N; gn++) begin : g_node
                    if (2 * gn + 1 < PN) begin : g_pair
                        assign sum[gr][gn] = lvl[gi-1].node[gr][2*gn] + lvl[gi-1].node[gr][2*gn+1];
                    end else begin : g_pass
                        // Unpaired term rides through to the next level unchanged
                        assign sum[gr][gn] = lvl[gi-1].node[gr][2*gn];
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    node <= '{default: '0};
                end else if (cen) begin
                    node <= sum;
                end
            end
        end
    end

    for (genvar gr = 0; gr < R; gr++) begin : g_out
        assign y[gr] = lvl[LATENCY-1].node[gr][0];
    end

endmodule

// File: tb/tb_matvec_mul.sv
// Self-checking bench for matvec_mul: directed corners, streaming, stalls,
// mid-stream reset and random vectors against a dot-product model.
module tb_matvec_mul;

    localparam int R   = 2;
    localparam int C   = 5;
    localparam int W_X = 3;
    localparam int W_K = 4;
    localparam int W_Y = 10;
    localparam int LAT = 4;

    logic                          clk;
    logic                          rst;
    logic                          cen;
    logic [R-1:0][C-1:0][W_K-1:0]  k_in;
    logic [C-1:0][W_X-1:0]         x_in;
    logic [R-1:0][W_Y-1:0]         y;

    typedef int vec_t [R];
    vec_t exp_q[$];

    int checks;
    int errors;

    matvec_mul #(.R(R), .C(C), .W_X(W_X), .W_K(W_K)) dut (
        .clk (clk),
        .rst (rst),
        .cen (cen),
        .k   (k_in),
        .x   (x_in),
        .y   (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t dot();
        vec_t res;
        int kv;
        int xv;
        for (int r = 0; r < R; r++) begin
            res[r] = 0;
            for (int c = 0; c < C; c++) begin
                kv = $signed(k_in[r][c]);
                xv = $signed(x_in[c]);
                res[r] += kv * xv;
            end
        end
        return res;
    endfunction

    function automatic int y_row(int r);
        int v;
        v = $signed(y[r]);
        return v;
    endfunction

    // Expected y after an edge is the result of the inputs taken LAT enabled
    // edges ago counting this one, or zero if reset happened since.
    task automatic step();
        vec_t zero;
        vec_t d;
        d = dot();
        @(posedge clk);
        if (rst) begin
            foreach (zero[r]) zero[r] = 0;
            exp_q.delete();
            for (int i = 0; i < LAT; i++) exp_q.push_back(zero);
        end else if (cen) begin
            exp_q.push_back(d);
            void'(exp_q.pop_front());
        end
        #1;
    endtask

    task automatic rand_inputs();
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                k_in[r][c] = W_K'($urandom_range(0, (1 << W_K) - 1));
        for (int c = 0; c < C; c++)
            x_in[c] = W_X'($urandom_range(0, (1 << W_X) - 1));
    endtask

    task automatic set_const(input int kv0, input int kv1, input int xv);
        for (int c = 0; c < C; c++) begin
            k_in[0][c] = W_K'(kv0);
            k_in[1][c] = W_K'(kv1);
            x_in[c]    = W_X'(xv);
        end
    endtask

    task automatic test_reset();
        rand_inputs();
        rst = 1'b1;
        cen = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int r = 0; r < R; r++) begin
            checks++;
            if (y_row(r) !== 0) begin
                errors++;
                $display("FAIL reset_y row%0d: got %0d expected 0", r, y_row(r));
            end
        end
        $display("test_reset: y=%0d,%0d", y_row(0), y_row(1));
    endtask

    task automatic test_latency();
        int exp0 [3];
        int exp1 [3];
        int kv0 [3];
        int kv1 [3];
        int xv  [3];
        kv0 = '{1, -8, -8};
        kv1 = '{-1, -8, -8};
        xv  = '{1, -4, 3};
        exp0 = '{5, 160, -120};
        exp1 = '{-5, 160, -120};
        for (int t = 0; t < 3; t++) begin
            rst = 1'b1;
            cen = 1'b1;
            step();
            rst = 1'b0;
            set_const(kv0[t], kv1[t], xv[t]);
            for (int e = 1; e <= LAT; e++) begin
                step();
                rand_inputs();
                if (e == LAT - 1) begin
                    checks++;
                    if (y_row(0) !== 0 || y_row(1) !== 0) begin
                        errors++;
                        $display("FAIL early_y case%0d: got %0d,%0d expected 0,0", t, y_row(0), y_row(1));
                    end
                end
            end
            checks++;
            if (y_row(0) !== exp0[t] || y_row(1) !== exp1[t]) begin
                errors++;
                $display("FAIL corner case%0d: got %0d,%0d expected %0d,%0d",
                         t, y_row(0), y_row(1), exp0[t], exp1[t]);
            end
            $display("test_latency case%0d: y=%0d,%0d", t, y_row(0), y_row(1));
        end
    endtask

    task automatic test_back_to_back();
        cen = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rand_inputs();
            step();
            for (int r = 0; r < R; r++) begin
                checks++;
                if (y_row(r) !== exp_q[0][r]) begin
                    errors++;
                    $display("FAIL stream cyc%0d row%0d: got %0d expected %0d", i, r, y_row(r), exp_q[0][r]);
                end
            end
            $display("test_back_to_back cyc%0d: y=%0d,%0d", i, y_row(0), y_row(1));
        end
    endtask

    task automatic test_cen_stall();
        int held [R];
        for (int i = 0; i < 12; i++) begin
            cen = (i >= 4 && i < 7) ? 1'b0 : 1'b1;
            rand_inputs();
            if (i == 4) foreach (held[r]) held[r] = exp_q[0][r];
            step();
            for (int r = 0; r < R; r++) begin
                checks++;
                if (y_row(r) !== exp_q[0][r]) begin
                    errors++;
                    $display("FAIL stall cyc%0d row%0d: got %0d expected %0d", i, r, y_row(r), exp_q[0][r]);
                end
                if (!cen) begin
                    checks++;
                    if (y_row(r) !== held[r]) begin
                        errors++;
                        $display("FAIL frozen cyc%0d row%0d: got %0d expected %0d", i, r, y_row(r), held[r]);
                    end
                end
            end
            $display("test_cen_stall cyc%0d cen=%0b: y=%0d,%0d", i, cen, y_row(0), y_row(1));
        end
    endtask

    task automatic test_reset_mid();
        for (int pass = 0; pass < 2; pass++) begin
            cen = 1'b1;
            for (int i = 0; i < 3; i++) begin
                rand_inputs();
                step();
            end
            rst = 1'b1;
            cen = pass[0];
            rand_inputs();
            step();
            rst = 1'b0;
            checks++;
            if (y_row(0) !== 0 || y_row(1) !== 0) begin
                errors++;
                $display("FAIL mid_reset pass%0d: got %0d,%0d expected 0,0", pass, y_row(0), y_row(1));
            end
            for (int i = 0; i < 8; i++) begin
                cen = (i == 2) ? 1'b0 : 1'b1;
                rand_inputs();
                step();
                for (int r = 0; r < R; r++) begin
                    checks++;
                    if (y_row(r) !== exp_q[0][r]) begin
                        errors++;
                        $display("FAIL post_reset pass%0d cyc%0d row%0d: got %0d expected %0d",
                                 pass, i, r, y_row(r), exp_q[0][r]);
                    end
                end
            end
            $display("test_reset_mid pass%0d: y=%0d,%0d", pass, y_row(0), y_row(1));
        end
    endtask

    task automatic test_random();
        cen = 1'b1;
        for (int i = 0; i < 100 + LAT; i++) begin
            rand_inputs();
            step();
            if (i >= LAT - 1) begin
                for (int r = 0; r < R; r++) begin
                    checks++;
                    if (y_row(r) !== exp_q[0][r]) begin
                        errors++;
                        $display("FAIL random vec%0d row%0d: got %0d expected %0d", i, r, y_row(r), exp_q[0][r]);
                    end
                end
                $display("test_random vec%0d: y=%0d,%0d", i, y_row(0), y_row(1));
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        cen = 1'b0;
        k_in = '0;
        x_in = '0;
        @(negedge clk);
        test_reset();
        test_latency();
        test_back_to_back();
        test_cen_stall();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
